// File: rtl/vend_dispenser_if.sv
// Bundle of request, actuator, sensor and status signals between the vending
// controller and its surroundings. Signal names are from the dispenser's view.
interface vend_dispenser_if;
    logic       vend_i;
    logic [1:0] change_i;
    logic       motor_o;
    logic       motor_done_i;
    logic       hopper_o;
    logic       coin_seen_i;
    logic       refill_i;
    logic       fault_clr_i;
    logic       busy_o;
    logic       fault_o;
    logic       overflow_o;
    logic       short_o;
    logic       bad_code_o;
    logic [7:0] bottle_cnt_o;
    logic [7:0] coin_cnt_o;

    modport slave (
        input  vend_i, change_i, motor_done_i, coin_seen_i, refill_i, fault_clr_i,
        output motor_o, hopper_o, busy_o, fault_o, overflow_o, short_o, bad_code_o,
               bottle_cnt_o, coin_cnt_o
    );

    modport master (
        output vend_i, change_i, motor_done_i, coin_seen_i, refill_i, fault_clr_i,
        input  motor_o, hopper_o, busy_o, fault_o, overflow_o, short_o, bad_code_o,
               bottle_cnt_o, coin_cnt_o
    );
endinterface

// File: rtl/vend_dispenser.sv
// Vending dispenser controller: queues vend/change requests, then drives the
// bottle motor and coin hopper one action at a time with a gap between actions,
// an actuator timeout leading to FAULT, and stock counters that never wrap.
module vend_dispenser #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACT_TIMEOUT = 255,
    parameter int GAP_CYCLES  = 2,
    parameter int BOTTLE_INIT = 15,
    parameter int COIN_INIT   = 31
) (
    input logic              clk,
    input logic              rst,
    vend_dispenser_if.slave  bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int TMAX = (ACT_TIMEOUT > GAP_CYCLES) ? ACT_TIMEOUT : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ACT_LAST   = TW'(ACT_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [7:0]    BOTTLE_RST = 8'(BOTTLE_INIT);
    localparam logic [7:0]    COIN_RST   = 8'(COIN_INIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BOTTLE = 3'd1,
        S_COIN   = 3'd2,
        S_GAP    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           job_vend_q, job_vend_d;
    logic [1:0]     job_coins_q, job_coins_d;
    logic [2:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     bottle_cnt_q, coin_cnt_q;
    logic           motor_q, hopper_q, fault_q, busy_q, overflow_q, short_q, bad_q;
    logic           motor_d, hopper_d, fault_d, busy_d, overflow_d, short_d, bad_d;

    logic           req_s, bad_s, push_s, pop_s, drop_s, full_s, empty_s;
    logic [2:0]     entry_s, head_s;
    logic           cand_vend_s, dec_vend_s, dec_short_s, short_set_s;
    logic [1:0]     cand_coins_s, dec_coins_s;
    state_t         dec_state_s;
    logic           bottle_dec_s, coin_dec_s;

    // A request is any cycle with a vend or a change code; code 11 queues as zero coins.
    assign req_s   = bus.vend_i | (bus.change_i != 2'b00);
    assign bad_s   = (bus.change_i == 2'b11);
    assign entry_s = {bus.vend_i, (bad_s ? 2'b00 : bus.change_i)};
    assign full_s  = (count_q == CW'(FIFO_DEPTH));
    assign empty_s = (count_q == CW'(0));
    assign pop_s   = (state_q == S_IDLE) && !empty_s;
    assign push_s  = req_s && (!full_s || pop_s);
    assign drop_s  = req_s && !push_s;
    assign head_s  = mem_q[rd_ptr_q];

    // The job considered at a decision point: FIFO head when idle, else the job register.
    assign cand_vend_s  = (state_q == S_IDLE) ? head_s[2]   : job_vend_q;
    assign cand_coins_s = (state_q == S_IDLE) ? head_s[1:0] : job_coins_q;

    // FIFO occupancy for the next cycle.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Request FIFO storage and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= entry_s;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Action decision: drop out-of-stock items, then bottle first, then coins.
    always_comb begin
        dec_vend_s  = cand_vend_s;
        dec_coins_s = cand_coins_s;
        dec_short_s = 1'b0;
        dec_state_s = S_IDLE;
        if (cand_vend_s && (bottle_cnt_q == 8'd0)) begin
            dec_vend_s  = 1'b0;
            dec_short_s = 1'b1;
        end else begin
            dec_vend_s  = cand_vend_s;
        end
        if ((cand_coins_s != 2'd0) && (coin_cnt_q == 8'd0)) begin
            dec_coins_s = 2'd0;
            dec_short_s = 1'b1;
        end else begin
            dec_coins_s = cand_coins_s;
        end
        if (dec_vend_s) begin
            dec_state_s = S_BOTTLE;
        end else if (dec_coins_s != 2'd0) begin
            dec_state_s = S_COIN;
        end else begin
            dec_state_s = S_IDLE;
        end
    end

    // Next-state logic: sequencing, actuator timeout and job bookkeeping.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        job_vend_d   = job_vend_q;
        job_coins_d  = job_coins_q;
        short_set_s  = 1'b0;
        bottle_dec_s = 1'b0;
        coin_dec_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    state_d     = dec_state_s;
                    job_vend_d  = dec_vend_s;
                    job_coins_d = dec_coins_s;
                    short_set_s = dec_short_s;
                    timer_d     = TW'(0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BOTTLE: begin
                if (bus.motor_done_i) begin
                    state_d      = S_GAP;
                    timer_d      = TW'(0);
                    job_vend_d   = 1'b0;
                    bottle_dec_s = 1'b1;
                end else if (timer_q == ACT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_COIN: begin
                if (bus.coin_seen_i) begin
                    state_d     = S_GAP;
                    timer_d     = TW'(0);
                    job_coins_d = job_coins_q - 2'd1;
                    coin_dec_s  = 1'b1;
                end else if (timer_q == ACT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d     = dec_state_s;
                    job_vend_d  = dec_vend_s;
                    job_coins_d = dec_coins_s;
                    short_set_s = dec_short_s;
                    timer_d     = TW'(0);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_FAULT: begin
                if (bus.fault_clr_i) begin
                    state_d     = S_IDLE;
                    job_vend_d  = 1'b0;
                    job_coins_d = 2'd0;
                    timer_d     = TW'(0);
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, timer and job register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= TW'(0);
            job_vend_q  <= 1'b0;
            job_coins_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            job_vend_q  <= job_vend_d;
            job_coins_q <= job_coins_d;
        end
    end

    // Stock counters: refill beats a same-cycle decrement, and they saturate at zero.
    always_ff @(posedge clk) begin
        if (rst || bus.refill_i) begin
            bottle_cnt_q <= BOTTLE_RST;
            coin_cnt_q   <= COIN_RST;
        end else begin
            if (bottle_dec_s && (bottle_cnt_q != 8'd0)) begin
                bottle_cnt_q <= bottle_cnt_q - 8'd1;
            end
            if (coin_dec_s && (coin_cnt_q != 8'd0)) begin
                coin_cnt_q <= coin_cnt_q - 8'd1;
            end
        end
    end

    // Output values derived from the next state; sticky flags clear on fault_clr.
    always_comb begin
        motor_d  = (state_d == S_BOTTLE);
        hopper_d = (state_d == S_COIN);
        fault_d  = (state_d == S_FAULT);
        busy_d   = (count_d != CW'(0)) || (state_d != S_IDLE);
        if (bus.fault_clr_i) begin
            overflow_d = 1'b0;
            short_d    = 1'b0;
            bad_d      = 1'b0;
        end else begin
            overflow_d = overflow_q | drop_s;
            short_d    = short_q | short_set_s;
            bad_d      = bad_q | (req_s & bad_s);
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            motor_q    <= 1'b0;
            hopper_q   <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            motor_q    <= motor_d;
            hopper_q   <= hopper_d;
            fault_q    <= fault_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            short_q    <= short_d;
            bad_q      <= bad_d;
        end
    end

    assign bus.motor_o      = motor_q;
    assign bus.hopper_o     = hopper_q;
    assign bus.fault_o      = fault_q;
    assign bus.busy_o       = busy_q;
    assign bus.overflow_o   = overflow_q;
    assign bus.short_o      = short_q;
    assign bus.bad_code_o   = bad_q;
    assign bus.bottle_cnt_o = bottle_cnt_q;
    assign bus.coin_cnt_o   = coin_cnt_q;
endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: directed timing scenarios, then randomized requests
// against a transaction-level stock/pulse model.
module tb_vend_dispenser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    vend_dispenser_if bus1();
    vend_dispenser_if bus2();

    int total = 0;
    int bad   = 0;
    int m1_pulses = 0, h1_pulses = 0, m2_pulses = 0, h2_pulses = 0;
    logic m1_prev = 1'b0, h1_prev = 1'b0, m2_prev = 1'b0, h2_prev = 1'b0;

    vend_dispenser dut1 (.clk(clk), .rst(rst), .bus(bus1));
    vend_dispenser #(.BOTTLE_INIT(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // Count actuator pulses (rising edges) on both instances.
    always @(negedge clk) begin
        m1_prev <= bus1.motor_o;
        h1_prev <= bus1.hopper_o;
        m2_prev <= bus2.motor_o;
        h2_prev <= bus2.hopper_o;
        if (bus1.motor_o && !m1_prev)  m1_pulses <= m1_pulses + 1;
        if (bus1.hopper_o && !h1_prev) h1_pulses <= h1_pulses + 1;
        if (bus2.motor_o && !m2_prev)  m2_pulses <= m2_pulses + 1;
        if (bus2.hopper_o && !h2_prev) h2_pulses <= h2_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as the machine: sensors answer after a random delay, plus stray pulses
    // while the actuator is off. Returns once dut1 is no longer busy.
    task automatic run_plant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bus1.motor_done_i = bus1.motor_o  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            bus1.coin_seen_i  = bus1.hopper_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            tick();
            if (!bus1.busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        bus1.motor_done_i = 1'b0;
        bus1.coin_seen_i  = 1'b0;
    endtask

    initial begin
        int  mp, hp, mc, m_bottle, m_coin, ncoin, exp_m, exp_h, mp0, hp0;
        bit  ok, m_short, m_bad, v;
        logic [1:0] code;

        bus1.vend_i = 1'b0; bus1.change_i = 2'b00; bus1.motor_done_i = 1'b0;
        bus1.coin_seen_i = 1'b0; bus1.refill_i = 1'b0; bus1.fault_clr_i = 1'b0;
        bus2.vend_i = 1'b0; bus2.change_i = 2'b00; bus2.motor_done_i = 1'b0;
        bus2.coin_seen_i = 1'b0; bus2.refill_i = 1'b0; bus2.fault_clr_i = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_bottle", 32'(bus1.bottle_cnt_o), 32'd15);
        check("rst_coin",   32'(bus1.coin_cnt_o),   32'd31);
        check("rst_motor",  32'(bus1.motor_o),      32'd0);
        check("rst_hopper", 32'(bus1.hopper_o),     32'd0);
        check("rst_busy",   32'(bus1.busy_o),       32'd0);
        check("rst_fault",  32'(bus1.fault_o),      32'd0);
        check("rst_flags",  32'({bus1.overflow_o, bus1.short_o, bus1.bad_code_o}), 32'd0);
        rst = 1'b0;
        tick();

        // Vend plus one coin: motor on after edges 1..4, sensor seen at edge 5
        bus1.vend_i = 1'b1; bus1.change_i = 2'b01;
        tick();                                         // edge 0
        bus1.vend_i = 1'b0; bus1.change_i = 2'b00;
        check("v1_motor_e0", 32'(bus1.motor_o), 32'd0);
        check("v1_busy_e0",  32'(bus1.busy_o),  32'd1);
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("v1_motor_e%0d", e), 32'(bus1.motor_o), 32'd1);
        end
        check("v1_bottle_hold", 32'(bus1.bottle_cnt_o), 32'd15);
        bus1.motor_done_i = 1'b1;
        tick();                                         // edge 5
        bus1.motor_done_i = 1'b0;
        check("v1_motor_off", 32'(bus1.motor_o),      32'd0);
        check("v1_bottle",    32'(bus1.bottle_cnt_o), 32'd14);
        tick();                                         // edge 6: still in gap
        check("v1_gap_hopper", 32'(bus1.hopper_o), 32'd0);
        tick();                                         // edge 7: coin action
        check("v1_hopper_on", 32'(bus1.hopper_o), 32'd1);
        check("v1_motor_gap", 32'(bus1.motor_o),  32'd0);
        bus1.coin_seen_i = 1'b1;
        tick();                                         // edge 8
        bus1.coin_seen_i = 1'b0;
        check("v1_hopper_off", 32'(bus1.hopper_o),   32'd0);
        check("v1_coin",       32'(bus1.coin_cnt_o), 32'd30);
        tick();
        check("v1_busy_gap", 32'(bus1.busy_o), 32'd1);
        tick();
        check("v1_busy_end", 32'(bus1.busy_o), 32'd0);

        // Refill restores both stocks
        bus1.refill_i = 1'b1;
        tick();
        bus1.refill_i = 1'b0;
        check("refill_bottle", 32'(bus1.bottle_cnt_o), 32'd15);
        check("refill_coin",   32'(bus1.coin_cnt_o),   32'd31);

        // Two coins alone: two hopper pulses with a two-cycle gap, no motor
        mp = m1_pulses;
        bus1.change_i = 2'b10;
        tick();                                         // edge 0
        bus1.change_i = 2'b00;
        tick();                                         // edge 1
        check("c2_hopper1", 32'(bus1.hopper_o), 32'd1);
        bus1.coin_seen_i = 1'b1;
        tick();                                         // edge 2
        bus1.coin_seen_i = 1'b0;
        check("c2_coin1",   32'(bus1.coin_cnt_o), 32'd30);
        check("c2_gap_a",   32'(bus1.hopper_o),   32'd0);
        tick();
        check("c2_gap_b",   32'(bus1.hopper_o),   32'd0);
        tick();
        check("c2_hopper2", 32'(bus1.hopper_o),   32'd1);
        bus1.coin_seen_i = 1'b1;
        tick();
        bus1.coin_seen_i = 1'b0;
        check("c2_coin2",   32'(bus1.coin_cnt_o), 32'd29);
        tick(); tick();
        check("c2_idle",    32'(bus1.busy_o),     32'd0);
        check("c2_no_motor", 32'(m1_pulses - mp), 32'd0);

        // Six back-to-back vends, no sensors: one in the job register, four queued,
        // the sixth dropped. The job then times out after 255 motor cycles.
        for (int i = 0; i < 6; i++) begin
            bus1.vend_i = 1'b1;
            tick();
        end
        bus1.vend_i = 1'b0;
        check("ovf_flag",   32'(bus1.overflow_o), 32'd1);
        check("ovf_motor",  32'(bus1.motor_o),    32'd1);
        mc = 5;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus1.motor_o) mc++;
            else begin
                ok = 1'b1;
                break;
            end
        end
        check("to_bound",     32'(ok),             32'd1);
        check("to_cycles",    32'(mc),             32'd255);
        check("to_fault",     32'(bus1.fault_o),   32'd1);
        check("to_bottle",    32'(bus1.bottle_cnt_o), 32'd15);
        tick(); tick();
        check("to_fault_hold", 32'(bus1.fault_o),  32'd1);
        check("to_motor_hold", 32'(bus1.motor_o),  32'd0);
        mp = m1_pulses; hp = h1_pulses;
        bus1.fault_clr_i = 1'b1;
        tick();
        bus1.fault_clr_i = 1'b0;
        check("clr_fault", 32'(bus1.fault_o),    32'd0);
        check("clr_ovf",   32'(bus1.overflow_o), 32'd0);
        check("clr_motor", 32'(bus1.motor_o),    32'd0);
        tick();
        check("clr_next_job", 32'(bus1.motor_o), 32'd1);
        run_plant(400, ok);
        check("q_drain_bound", 32'(ok), 32'd1);
        check("q_served",      32'(m1_pulses - mp), 32'd4);
        check("q_no_hopper",   32'(h1_pulses - hp), 32'd0);
        check("q_bottle",      32'(bus1.bottle_cnt_o), 32'd11);

        // No bottles stocked: vend skipped with short, coin still paid; code 11 flagged
        bus2.vend_i = 1'b1; bus2.change_i = 2'b01;
        tick();
        bus2.vend_i = 1'b0; bus2.change_i = 2'b00;
        tick();
        check("nb_short",  32'(bus2.short_o),  32'd1);
        check("nb_hopper", 32'(bus2.hopper_o), 32'd1);
        bus2.coin_seen_i = 1'b1;
        tick();
        bus2.coin_seen_i = 1'b0;
        tick(); tick();
        check("nb_idle",    32'(bus2.busy_o),     32'd0);
        check("nb_coin",    32'(bus2.coin_cnt_o), 32'd30);
        check("nb_nomotor", 32'(m2_pulses),       32'd0);
        bus2.change_i = 2'b11;
        tick();
        bus2.change_i = 2'b00;
        check("bc_flag", 32'(bus2.bad_code_o), 32'd1);
        tick(); tick(); tick();
        check("bc_idle",   32'(bus2.busy_o), 32'd0);
        check("bc_pulses", 32'(h2_pulses),   32'd1);
        check("bc_coin",   32'(bus2.coin_cnt_o), 32'd30);

        // Randomized requests against a stock/pulse model
        bus1.refill_i = 1'b1; bus1.fault_clr_i = 1'b1;
        tick();
        bus1.refill_i = 1'b0; bus1.fault_clr_i = 1'b0;
        m_bottle = 15; m_coin = 31; m_short = 1'b0; m_bad = 1'b0;
        exp_m = 0; exp_h = 0;
        mp0 = m1_pulses; hp0 = h1_pulses;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                bus1.refill_i = 1'b1;
                tick();
                bus1.refill_i = 1'b0;
                m_bottle = 15; m_coin = 31;
            end
            if ($urandom_range(0, 9) == 0) begin
                bus1.fault_clr_i = 1'b1;
                tick();
                bus1.fault_clr_i = 1'b0;
                m_short = 1'b0; m_bad = 1'b0;
            end
            v    = 1'($urandom_range(0, 1));
            code = 2'($urandom_range(0, 3));
            if (!v && code == 2'b00) code = 2'b01;
            if (code == 2'b11) m_bad = 1'b1;
            ncoin = (code == 2'b11) ? 0 : int'(code);
            if (v) begin
                if (m_bottle > 0) begin
                    m_bottle--;
                    exp_m++;
                end else begin
                    m_short = 1'b1;
                end
            end
            for (int k = 0; k < ncoin; k++) begin
                if (m_coin > 0) begin
                    m_coin--;
                    exp_h++;
                end else begin
                    m_short = 1'b1;
                    break;
                end
            end
            bus1.vend_i = v; bus1.change_i = code;
            tick();
            bus1.vend_i = 1'b0; bus1.change_i = 2'b00;
            run_plant(200, ok);
            check($sformatf("r%0d_bound", t),  32'(ok), 32'd1);
            check($sformatf("r%0d_bottle", t), 32'(bus1.bottle_cnt_o), 32'(m_bottle));
            check($sformatf("r%0d_coin", t),   32'(bus1.coin_cnt_o),   32'(m_coin));
            check($sformatf("r%0d_motor", t),  32'(m1_pulses - mp0),   32'(exp_m));
            check($sformatf("r%0d_hopper", t), 32'(h1_pulses - hp0),   32'(exp_h));
            check($sformatf("r%0d_short", t),  32'(bus1.short_o),      32'(m_short));
            check($sformatf("r%0d_bad", t),    32'(bus1.bad_code_o),   32'(m_bad));
        end

        // Reset during an actuation
        bus1.vend_i = 1'b1; bus1.change_i = 2'b00;
        tick();
        bus1.vend_i = 1'b0;
        tick();
        check("mid_motor_on", 32'(bus1.motor_o), 32'(bus1.bottle_cnt_o != 8'd0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_motor",  32'(bus1.motor_o),      32'd0);
        check("mid_rst_busy",   32'(bus1.busy_o),       32'd0);
        check("mid_rst_bottle", 32'(bus1.bottle_cnt_o), 32'd15);
        check("mid_rst_flags",  32'({bus1.overflow_o, bus1.short_o, bus1.bad_code_o}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
